axi_master_slice: RTL and testbench



---
 rtl/axi_slice_pkg.sv | 68 ++++++
 rtl/axi_master_slice_if.sv | 44 ++++
 rtl/axi_slice_ch.sv | 138 +++++++++++++
 rtl/axi_master_slice.sv | 100 ++++++++++
 tb/tb_axi_master_slice.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_slice_pkg.sv
// ============================================================================
// axi_slice_pkg : payload types, width constants and modes for the AXI slice
// Revision 1.0
// ============================================================================
`default_nettype none

package axi_slice_pkg;

    // Default field widths for the current bus generation
    localparam int AXI_ID_BITS   = 4;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;

    localparam int SIZE_BITS  = 3;
    localparam int BURST_BITS = 2;
    localparam int RESP_BITS  = 2;

    typedef struct packed {
        logic [AXI_ID_BITS-1:0]   id;
        logic [AXI_ADDR_BITS-1:0] addr;
        logic [AXI_LEN_BITS-1:0]  len;
        logic [SIZE_BITS-1:0]     size;
        logic [BURST_BITS-1:0]    burst;
    } aw_pay_t;

    typedef struct packed {
        logic [AXI_ID_BITS-1:0]   id;
        logic [AXI_ADDR_BITS-1:0] addr;
        logic [AXI_LEN_BITS-1:0]  len;
        logic [SIZE_BITS-1:0]     size;
        logic [BURST_BITS-1:0]    burst;
    } ar_pay_t;

    typedef struct packed {
        logic [AXI_DATA_BITS-1:0] data;
        logic [AXI_STRB_BITS-1:0] strb;
        logic                     last;
    } w_pay_t;

    typedef struct packed {
        logic [AXI_ID_BITS-1:0] id;
        logic [RESP_BITS-1:0]   resp;
    } b_pay_t;

    typedef struct packed {
        logic [AXI_ID_BITS-1:0]   id;
        logic [AXI_DATA_BITS-1:0] data;
        logic [RESP_BITS-1:0]     resp;
        logic                     last;
    } r_pay_t;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        FWD    = 2'd1,
        FULL   = 2'd2
    } slice_mode_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_master_slice_if.sv
// ============================================================================
// axi_master_slice_if : five-channel AXI4 bus bundle with master/slave views
// Revision 1.0
// ============================================================================
`default_nettype none

interface axi_master_slice_if;
    import axi_slice_pkg::*;

    aw_pay_t aw_pay;
    logic    aw_valid;
    logic    aw_ready;
    w_pay_t  w_pay;
    logic    w_valid;
    logic    w_ready;
    b_pay_t  b_pay;
    logic    b_valid;
    logic    b_ready;
    ar_pay_t ar_pay;
    logic    ar_valid;
    logic    ar_ready;
    r_pay_t  r_pay;
    logic    r_valid;
    logic    r_ready;

    modport mst (
        output aw_pay, aw_valid, input  aw_ready,
        output w_pay,  w_valid,  input  w_ready,
        input  b_pay,  b_valid,  output b_ready,
        output ar_pay, ar_valid, input  ar_ready,
        input  r_pay,  r_valid,  output r_ready
    );

    modport slv (
        input  aw_pay, aw_valid, output aw_ready,
        input  w_pay,  w_valid,  output w_ready,
        output b_pay,  b_valid,  input  b_ready,
        input  ar_pay, ar_valid, output ar_ready,
        output r_pay,  r_valid,  input  r_ready
    );

endinterface

`default_nettype wire

// File: rtl/axi_slice_ch.sv
// ============================================================================
// axi_slice_ch : generic valid/ready slice, bypass / forward / two-entry skid
// Revision 1.0
// ============================================================================
`default_nettype none

module axi_slice_ch
    import axi_slice_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] up_pay,
    input  wire logic             up_valid,
    output logic                  up_ready,
    output logic      [WIDTH-1:0] dn_pay,
    output logic                  dn_valid,
    input  wire logic             dn_ready
);

    if (MODE == int'(BYPASS)) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign dn_pay   = up_pay;
        assign dn_valid = up_valid;
        assign up_ready = dn_ready;

    end else if (MODE == int'(FWD)) begin : g_fwd
        logic             push;
        logic             valid_q;
        logic [WIDTH-1:0] pay_q;

        assign up_ready = ~valid_q | dn_ready;
        assign push     = up_valid & up_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                pay_q   <= '0;
            end else begin
                valid_q <= push | (valid_q & ~dn_ready);
                if (push) begin
                    pay_q <= up_pay;
                end
            end
        end

        assign dn_valid = valid_q;
        assign dn_pay   = pay_q;

    end else begin : g_full
        skid_state_e      state;
        skid_state_e      state_nxt;
        logic             push;
        logic             pop;
        logic             ready_q;
        logic             valid_q;
        logic             load_main_up;
        logic             load_main_skid;
        logic             load_skid;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] skid_q;

        assign push = up_valid & ready_q;
        assign pop  = valid_q & dn_ready;

        // Handshake outputs are separate flops so neither side sees a combinational path
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= EMPTY;
                ready_q <= 1'b1;
                valid_q <= 1'b0;
            end else begin
                state   <= state_nxt;
                ready_q <= (state_nxt != TWO);
                valid_q <= (state_nxt != EMPTY);
            end
        end

        always_comb begin
            state_nxt      = state;
            load_main_up   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt    = ONE;
                        load_main_up = 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (pop && !push) begin
                        state_nxt = EMPTY;
                    end else if (push && pop) begin
                        load_main_up = 1'b1;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_q <= '0;
                skid_q <= '0;
            end else begin
                if (load_main_up) begin
                    main_q <= up_pay;
                end else if (load_main_skid) begin
                    main_q <= skid_q;
                end
                if (load_skid) begin
                    skid_q <= up_pay;
                end
            end
        end

        assign up_ready = ready_q;
        assign dn_valid = valid_q;
        assign dn_pay   = main_q;
    end

endmodule

`default_nettype wire

// File: rtl/axi_master_slice.sv
// ============================================================================
// axi_master_slice : AXI4 register slice, one independent slice per channel
// Revision 1.0
// ============================================================================
`default_nettype none

module axi_master_slice
    import axi_slice_pkg::*;
#(
    parameter int ID_BITS   = AXI_ID_BITS,
    parameter int ADDR_BITS = AXI_ADDR_BITS,
    parameter int DATA_BITS = AXI_DATA_BITS,
    parameter int LEN_BITS  = AXI_LEN_BITS,
    parameter int MODE_AW   = 2,
    parameter int MODE_W    = 2,
    parameter int MODE_B    = 1,
    parameter int MODE_AR   = 2,
    parameter int MODE_R    = 2
) (
    input  wire logic   ACLK,
    input  wire logic   ARESETn,
    axi_master_slice_if.slv s_axi,
    axi_master_slice_if.mst m_axi
);

    localparam int AX_W = ID_BITS + ADDR_BITS + LEN_BITS + SIZE_BITS + BURST_BITS;
    localparam int W_W  = DATA_BITS + DATA_BITS / 8 + 1;
    localparam int B_W  = ID_BITS + RESP_BITS;
    localparam int R_W  = ID_BITS + DATA_BITS + RESP_BITS + 1;

    logic [AX_W-1:0] aw_dn;
    logic [W_W-1:0]  w_dn;
    logic [B_W-1:0]  b_dn;
    logic [AX_W-1:0] ar_dn;
    logic [R_W-1:0]  r_dn;

    axi_slice_ch #(.WIDTH(AX_W), .MODE(MODE_AW)) u_aw (
        .clk      (ACLK),
        .rst_n    (ARESETn),
        .up_pay   (s_axi.aw_pay),
        .up_valid (s_axi.aw_valid),
        .up_ready (s_axi.aw_ready),
        .dn_pay   (aw_dn),
        .dn_valid (m_axi.aw_valid),
        .dn_ready (m_axi.aw_ready)
    );
    assign m_axi.aw_pay = aw_pay_t'(aw_dn);

    axi_slice_ch #(.WIDTH(W_W), .MODE(MODE_W)) u_w (
        .clk      (ACLK),
        .rst_n    (ARESETn),
        .up_pay   (s_axi.w_pay),
        .up_valid (s_axi.w_valid),
        .up_ready (s_axi.w_ready),
        .dn_pay   (w_dn),
        .dn_valid (m_axi.w_valid),
        .dn_ready (m_axi.w_ready)
    );
    assign m_axi.w_pay = w_pay_t'(w_dn);

    // Response channels flow bridge -> master
    axi_slice_ch #(.WIDTH(B_W), .MODE(MODE_B)) u_b (
        .clk      (ACLK),
        .rst_n    (ARESETn),
        .up_pay   (m_axi.b_pay),
        .up_valid (m_axi.b_valid),
        .up_ready (m_axi.b_ready),
        .dn_pay   (b_dn),
        .dn_valid (s_axi.b_valid),
        .dn_ready (s_axi.b_ready)
    );
    assign s_axi.b_pay = b_pay_t'(b_dn);

    axi_slice_ch #(.WIDTH(AX_W), .MODE(MODE_AR)) u_ar (
        .clk      (ACLK),
        .rst_n    (ARESETn),
        .up_pay   (s_axi.ar_pay),
        .up_valid (s_axi.ar_valid),
        .up_ready (s_axi.ar_ready),
        .dn_pay   (ar_dn),
        .dn_valid (m_axi.ar_valid),
        .dn_ready (m_axi.ar_ready)
    );
    assign m_axi.ar_pay = ar_pay_t'(ar_dn);

    axi_slice_ch #(.WIDTH(R_W), .MODE(MODE_R)) u_r (
        .clk      (ACLK),
        .rst_n    (ARESETn),
        .up_pay   (m_axi.r_pay),
        .up_valid (m_axi.r_valid),
        .up_ready (m_axi.r_ready),
        .dn_pay   (r_dn),
        .dn_valid (s_axi.r_valid),
        .dn_ready (s_axi.r_ready)
    );
    assign s_axi.r_pay = r_pay_t'(r_dn);

endmodule

`default_nettype wire

// File: tb/tb_axi_master_slice.sv
// ============================================================================
// tb_axi_master_slice : randomized + directed bench with per-channel FIFO model
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axi_master_slice;
    import axi_slice_pkg::*;

    localparam int M_AW = 2;
    localparam int M_W  = 2;
    localparam int M_B  = 0;
    localparam int M_AR = 2;
    localparam int M_R  = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_master_slice_if s_axi ();
    axi_master_slice_if m_axi ();

    axi_master_slice #(
        .MODE_AW (M_AW),
        .MODE_W  (M_W),
        .MODE_B  (M_B),
        .MODE_AR (M_AR),
        .MODE_R  (M_R)
    ) dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .s_axi   (s_axi),
        .m_axi   (m_axi)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: every channel is a FIFO of beats in flight inside the slice
    logic [63:0] mem [5][256];
    int          wr [5];
    int          rd [5];
    logic        push_f [5];
    int          pops [5];
    string       nm [5] = '{"aw", "w", "b", "ar", "r"};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic reset_model();
        for (int c = 0; c < 5; c++) begin
            rd[c]     = wr[c];
            push_f[c] = 1'b0;
        end
    endtask

    task automatic step_ch(input int ch, input int mode, input logic uv, input logic ur,
                           input logic dv, input logic dr, input logic [63:0] up,
                           input logic [63:0] dn);
        int          occ;
        logic        e_ur;
        logic        e_dv;
        logic [63:0] e_pay;
        occ = wr[ch] - rd[ch];
        case (mode)
            0: begin
                e_ur  = dr;
                e_dv  = uv;
                e_pay = up;
            end
            1: begin
                e_dv  = (occ > 0);
                e_ur  = (occ == 0) || dr;
                e_pay = mem[ch][rd[ch] % 256];
            end
            default: begin
                e_dv  = (occ > 0);
                e_ur  = (occ < 2);
                e_pay = mem[ch][rd[ch] % 256];
            end
        endcase
        check_val({nm[ch], "_up_ready"}, 64'(ur), 64'(e_ur));
        check_val({nm[ch], "_dn_valid"}, 64'(dv), 64'(e_dv));
        if (e_dv) check_val({nm[ch], "_dn_pay"}, dn, e_pay);
        else      check_val({nm[ch], "_dn_pay_known"}, 64'($isunknown(dn)), 64'd0);
        push_f[ch] = uv && e_ur;
        if (e_dv && dr) begin
            pops[ch]++;
            if (mode != 0) rd[ch]++;
        end
        if (push_f[ch] && mode != 0) begin
            mem[ch][wr[ch] % 256] = up;
            wr[ch]++;
        end
    endtask

    // Inputs are driven at posedge+1; evaluation happens at the falling edge
    task automatic tick();
        #4;
        step_ch(0, M_AW, s_axi.aw_valid, s_axi.aw_ready, m_axi.aw_valid, m_axi.aw_ready,
                64'(s_axi.aw_pay), 64'(m_axi.aw_pay));
        step_ch(1, M_W, s_axi.w_valid, s_axi.w_ready, m_axi.w_valid, m_axi.w_ready,
                64'(s_axi.w_pay), 64'(m_axi.w_pay));
        step_ch(2, M_B, m_axi.b_valid, m_axi.b_ready, s_axi.b_valid, s_axi.b_ready,
                64'(m_axi.b_pay), 64'(s_axi.b_pay));
        step_ch(3, M_AR, s_axi.ar_valid, s_axi.ar_ready, m_axi.ar_valid, m_axi.ar_ready,
                64'(s_axi.ar_pay), 64'(m_axi.ar_pay));
        step_ch(4, M_R, m_axi.r_valid, m_axi.r_ready, s_axi.r_valid, s_axi.r_ready,
                64'(m_axi.r_pay), 64'(s_axi.r_pay));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_axi.aw_valid = 1'b0; s_axi.w_valid = 1'b0; s_axi.ar_valid = 1'b0;
        m_axi.b_valid  = 1'b0; m_axi.r_valid = 1'b0;
        m_axi.aw_ready = 1'b1; m_axi.w_ready = 1'b1; m_axi.ar_ready = 1'b1;
        s_axi.b_ready  = 1'b1; s_axi.r_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx;
        int          base;
        int          guard;
        logic [63:0] r;
        logic        w_pat [6];
        w_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        for (int c = 0; c < 5; c++) begin
            wr[c] = 0; rd[c] = 0; pops[c] = 0; push_f[c] = 1'b0;
        end
        s_axi.aw_pay = '0; s_axi.w_pay = '0; s_axi.ar_pay = '0;
        m_axi.b_pay  = '0; m_axi.r_pay = '0;
        idle();

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("rst_s_aw_ready", 64'(s_axi.aw_ready), 64'd1);
        check_val("rst_s_w_ready",  64'(s_axi.w_ready),  64'd1);
        check_val("rst_s_ar_ready", 64'(s_axi.ar_ready), 64'd1);
        check_val("rst_m_aw_valid", 64'(m_axi.aw_valid), 64'd0);
        check_val("rst_m_ar_valid", 64'(m_axi.ar_valid), 64'd0);
        check_val("rst_s_r_valid",  64'(s_axi.r_valid),  64'd0);
        check_val("rst_m_aw_pay",   64'(m_axi.aw_pay),   64'd0);
        check_val("rst_s_r_pay",    64'(s_axi.r_pay),    64'd0);
        rst_n = 1'b1;
        tick();

        // AW full mode: four back-to-back addresses
        for (int i = 0; i < 4; i++) begin
            s_axi.aw_valid      = 1'b1;
            s_axi.aw_pay.id     = 4'(i);
            s_axi.aw_pay.addr   = 32'h100 + 32'(4 * i);
            s_axi.aw_pay.len    = 4'd0;
            s_axi.aw_pay.size   = 3'd2;
            s_axi.aw_pay.burst  = 2'd1;
            tick();
            check_val("aw_b2b_accept", 64'(push_f[0]), 64'd1);
        end
        s_axi.aw_valid = 1'b0;
        tick();
        tick();

        // W full mode burst with stalling consumer
        idx = 0;
        for (int t = 0; t < 10; t++) begin
            s_axi.w_valid     = (idx < 4);
            s_axi.w_pay.data  = 32'hA0 + 32'(idx);
            s_axi.w_pay.strb  = 4'hF;
            s_axi.w_pay.last  = (idx == 3);
            m_axi.w_ready     = (t < 6) ? w_pat[t] : 1'b1;
            tick();
            if (push_f[1]) idx++;
        end
        check_val("w_beats_accepted", 64'(idx), 64'd4);
        check_val("w_beats_delivered", 64'(pops[1]), 64'd4);
        idle();
        tick();

        // R forward mode: single beat held for three cycles
        base = pops[4];
        m_axi.r_valid     = 1'b1;
        m_axi.r_pay.id    = 4'd2;
        m_axi.r_pay.data  = 32'hDEAD_BEEF;
        m_axi.r_pay.resp  = 2'd0;
        m_axi.r_pay.last  = 1'b1;
        s_axi.r_ready     = 1'b0;
        tick();
        m_axi.r_valid = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            check_val("r_hold_data", 64'(s_axi.r_pay.data), 64'hDEAD_BEEF);
        end
        s_axi.r_ready = 1'b1;
        tick();
        tick();
        check_val("r_once", 64'(pops[4] - base), 64'd1);

        // B bypass: same-cycle pass-through in both directions
        for (int t = 0; t < 4; t++) begin
            m_axi.b_valid     = 1'b1;
            m_axi.b_pay.id    = 4'(t + 5);
            m_axi.b_pay.resp  = 2'(t);
            s_axi.b_ready     = t[0];
            tick();
        end
        idle();
        tick();

        // Reset mid-operation with two AR entries held
        m_axi.ar_ready     = 1'b0;
        s_axi.ar_valid     = 1'b1;
        s_axi.ar_pay       = '0;
        s_axi.ar_pay.addr  = 32'h200;
        tick();
        s_axi.ar_pay.addr  = 32'h204;
        tick();
        check_val("ar_two_full", 64'(s_axi.ar_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_rst_valid", 64'(m_axi.ar_valid), 64'd0);
        check_val("ar_rst_ready", 64'(s_axi.ar_ready), 64'd1);
        check_val("ar_rst_pay",   64'(m_axi.ar_pay),   64'd0);
        reset_model();
        idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) tick();

        // Randomized traffic on all channels
        guard = 0;
        while ((pops[0] < 100 || pops[1] < 100 || pops[2] < 100 || pops[3] < 100 ||
                pops[4] < 100) && guard < 3000) begin
            if (!s_axi.aw_valid || push_f[0]) begin
                r = rnd64();
                s_axi.aw_valid = ($urandom_range(0, 9) < 7);
                s_axi.aw_pay   = aw_pay_t'(r[$bits(aw_pay_t)-1:0]);
            end
            if (!s_axi.w_valid || push_f[1]) begin
                r = rnd64();
                s_axi.w_valid = ($urandom_range(0, 9) < 7);
                s_axi.w_pay   = w_pay_t'(r[$bits(w_pay_t)-1:0]);
            end
            if (!m_axi.b_valid || push_f[2]) begin
                r = rnd64();
                m_axi.b_valid = ($urandom_range(0, 9) < 7);
                m_axi.b_pay   = b_pay_t'(r[$bits(b_pay_t)-1:0]);
            end
            if (!s_axi.ar_valid || push_f[3]) begin
                r = rnd64();
                s_axi.ar_valid = ($urandom_range(0, 9) < 7);
                s_axi.ar_pay   = ar_pay_t'(r[$bits(ar_pay_t)-1:0]);
            end
            if (!m_axi.r_valid || push_f[4]) begin
                r = rnd64();
                m_axi.r_valid = ($urandom_range(0, 9) < 7);
                m_axi.r_pay   = r_pay_t'(r[$bits(r_pay_t)-1:0]);
            end
            m_axi.aw_ready = ($urandom_range(0, 9) < 6);
            m_axi.w_ready  = ($urandom_range(0, 9) < 6);
            s_axi.b_ready  = ($urandom_range(0, 9) < 6);
            m_axi.ar_ready = ($urandom_range(0, 9) < 6);
            s_axi.r_ready  = ($urandom_range(0, 9) < 6);
            tick();
            guard++;
        end
        for (int c = 0; c < 5; c++) begin
            check_val({nm[c], "_rand_beats_ge100"}, 64'(pops[c] >= 100), 64'd1);
        end

        // Drain: everything pushed must come out, nothing extra
        idle();
        for (int t = 0; t < 4; t++) tick();
        for (int c = 0; c < 5; c++) begin
            check_val({nm[c], "_drained"}, 64'(wr[c] - rd[c]), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
